decode_stage: RTL and testbench
===============================

Name: decode_stage

Overview:
Instruction decode stage of the RV32I core. It sits between fetch and the ALU/execute stage.
- Accepts a fetched 32-bit instruction and PC over a valid/ready handshake.
- Classifies the instruction into an inst_format_e value and extracts register indices, funct3/funct7 (alu_funct3_e / alu_funct7_e) and the sign-extended immediate.
- Presents the result on a registered valid/ready output.
- A 2-entry skid buffer keeps in_ready registered, so there is no combinational ready path from execute to fetch.

Parameters:
XLEN, 32, width of PC and immediate datapath (only 32 supported)

Ports:
clk  input  1  clock; all logic on rising edge
rst_n  input  1  reset, synchronous, active-low
flush  input  1  discard all held instructions (branch redirect)
in_valid  input  1  fetch offers instruction
in_ready  output  1  stage can accept; registered
in_inst  input  32  raw instruction word
in_pc  input  XLEN  PC of in_inst
out_valid  output  1  decoded instruction available
out_ready  input  1  execute accepts
out_pc  output  XLEN  PC of decoded instruction
out_format  output  types::inst_format_e  instruction format
out_rd  output  5  inst[11:7]
out_rs1  output  5  inst[19:15]
out_rs2  output  5  inst[24:20]
out_funct3  output  types::alu_funct3_e  inst[14:12]
out_funct7  output  types::alu_funct7_e  inst[31:25]
out_imm  output  XLEN  sign-extended immediate
out_illegal  output  1  out_format == INVALID_TYPE

Behaviour:
- Handshake:
  - accept = in_valid && in_ready.
  - emit = out_valid && out_ready.
  - Producer holds in_* stable while in_valid && !in_ready. Consumer sees out_* stable while out_valid && !out_ready.
- Decode is combinational on in_inst. Decoded fields are stored, not the raw word.
- Format, by opcode inst[6:0]:
  - 0110011 -> R_TYPE.
  - 0010011, 0000011, 1100111, 1110011 -> I_TYPE.
  - 0100011 -> S_TYPE.
  - 1100011 -> B_TYPE.
  - 0110111, 0010111 -> U_TYPE.
  - 1101111 -> J_TYPE.
  - Any other opcode -> INVALID_TYPE. Since every valid opcode above ends in 11, any inst[1:0] != 2'b11 is also INVALID_TYPE.
- Immediate (standard RV32I packing, sign bit inst[31]):
  - I: inst[31:20].
  - S: {inst[31:25], inst[11:7]}.
  - B: {inst[31], inst[7], inst[30:25], inst[11:8], 0}.
  - U: {inst[31:12], 12'b0}.
  - J: {inst[31], inst[19:12], inst[20], inst[30:21], 0}.
  - R and INVALID_TYPE: 0.
- rd/rs1/rs2/funct3/funct7 are passed through raw, whatever the format.
- Storage: main register (drives out_*) plus skid register. State machine:
  - EMPTY: out_valid=0, in_ready=1. accept -> main, go ONE.
  - ONE: out_valid=1, in_ready=1.
    - accept && emit: main <= new, stay ONE.
    - accept && !emit: skid <= new, go TWO.
    - !accept && emit: go EMPTY.
    - otherwise hold.
  - TWO: out_valid=1, in_ready=0.
    - emit: main <= skid, go ONE.
    - otherwise hold.
- Latency: 1 cycle from accept to out_valid when the stage is empty. Throughput: 1 instruction per cycle when out_ready stays high.
- Ordering: strict FIFO. No instruction is lost or duplicated.
- flush: next state is EMPTY and all held entries are dropped. flush overrides a same-cycle accept (the word is dropped) and a same-cycle emit.
- Reset (rst_n low at clk edge, including mid-stream):
  - State EMPTY, out_valid=0, in_ready=1.
  - out_pc=0, out_format=INVALID_TYPE, out_rd/rs1/rs2=0, out_funct3=ADD, out_funct7=POS, out_imm=0, out_illegal=1.
- Data registers load only on their load condition. They hold otherwise.

Test Plan:
- Decode, out_ready=1: 0x00500093 (addi x1,x0,5) at pc 0x100 -> next cycle out_valid=1, format I_TYPE, rd=1, rs1=0, funct3=ADD, imm=0x00000005, pc=0x100.
- Decode: 0x402081B3 (sub x3,x1,x2) -> R_TYPE, funct7=NEG, rs1=1, rs2=2, rd=3, imm=0. Then 0xFE000EE3 (beq x0,x0,-4) -> B_TYPE, imm=0xFFFFFFFC.
- Illegal: 0x00000000 -> INVALID_TYPE, out_illegal=1, imm=0.
- Backpressure: stream A,B,C with in_valid=1 and out_ready=0 for 3 cycles.
  - A and B accepted, in_ready=0 from the cycle after B is accepted, C held.
  - out_ready=1 -> A, B, C emitted in order on consecutive cycles with no duplicates.
- Flush in TWO with a same-cycle in_valid -> next cycle out_valid=0, in_ready=1. The flushed word never appears on the output.
- rst_n=0 for 1 cycle while in TWO -> all outputs at reset values next cycle. A following accept emits normally after 1 cycle.

Source files
------------

// File: rtl/decode_stage.sv
// RV32I decode stage: classifies the instruction, extracts fields and immediate,
// and buffers up to two decoded entries so in_ready comes straight from a flop.

package types;
   typedef enum logic [2:0] {
      R_TYPE       = 3'd0,
      I_TYPE       = 3'd1,
      S_TYPE       = 3'd2,
      B_TYPE       = 3'd3,
      U_TYPE       = 3'd4,
      J_TYPE       = 3'd5,
      INVALID_TYPE = 3'd6
   } inst_format_e;

   typedef enum logic [2:0] {
      ADD  = 3'b000,
      SLL  = 3'b001,
      SLT  = 3'b010,
      SLTU = 3'b011,
      XOR  = 3'b100,
      SR   = 3'b101,
      OR   = 3'b110,
      AND  = 3'b111
   } alu_funct3_e;

   typedef enum logic [6:0] {
      POS = 7'b0000000,
      NEG = 7'b0100000
   } alu_funct7_e;
endpackage

module decode_stage #(
   parameter int unsigned XLEN = 32
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                flush,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [31:0]         in_inst,
   input  logic [XLEN-1:0]     in_pc,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [XLEN-1:0]     out_pc,
   output types::inst_format_e out_format,
   output logic [4:0]          out_rd,
   output logic [4:0]          out_rs1,
   output logic [4:0]          out_rs2,
   output types::alu_funct3_e  out_funct3,
   output types::alu_funct7_e  out_funct7,
   output logic [XLEN-1:0]     out_imm,
   output logic                out_illegal
);
   import types::*;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      inst_format_e    format;
      logic [4:0]      rd;
      logic [4:0]      rs1;
      logic [4:0]      rs2;
      alu_funct3_e     funct3;
      alu_funct7_e     funct7;
      logic [XLEN-1:0] imm;
   } dec_t;

   typedef enum logic [1:0] {StEmpty, StOne, StTwo} state_e;

   localparam dec_t DecReset = '{
      pc:     '0,
      format: INVALID_TYPE,
      rd:     '0,
      rs1:    '0,
      rs2:    '0,
      funct3: ADD,
      funct7: POS,
      imm:    '0
   };

   state_e state_q, state_d;
   dec_t   main_q, main_d;
   dec_t   skid_q, skid_d;
   logic   in_ready_q, in_ready_d;
   logic   out_valid_q, out_valid_d;

   dec_t         dec;
   inst_format_e fmt;
   logic         accept;
   logic         emit;

   always_comb begin
      fmt = INVALID_TYPE;
      unique case (in_inst[6:0])
         7'b0110011:                                     fmt = R_TYPE;
         7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011: fmt = I_TYPE;
         7'b0100011:                                     fmt = S_TYPE;
         7'b1100011:                                     fmt = B_TYPE;
         7'b0110111, 7'b0010111:                         fmt = U_TYPE;
         7'b1101111:                                     fmt = J_TYPE;
         default:                                        fmt = INVALID_TYPE;
      endcase
   end

   always_comb begin
      dec        = DecReset;
      dec.pc     = in_pc;
      dec.format = fmt;
      dec.rd     = in_inst[11:7];
      dec.rs1    = in_inst[19:15];
      dec.rs2    = in_inst[24:20];
      dec.funct3 = alu_funct3_e'(in_inst[14:12]);
      dec.funct7 = alu_funct7_e'(in_inst[31:25]);
      unique case (fmt)
         I_TYPE:  dec.imm = {{20{in_inst[31]}}, in_inst[31:20]};
         S_TYPE:  dec.imm = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
         B_TYPE:  dec.imm = {{19{in_inst[31]}}, in_inst[31], in_inst[7], in_inst[30:25],
                             in_inst[11:8], 1'b0};
         U_TYPE:  dec.imm = {in_inst[31:12], 12'b0};
         J_TYPE:  dec.imm = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12], in_inst[20],
                             in_inst[30:21], 1'b0};
         default: dec.imm = '0;
      endcase
   end

   assign accept = in_valid && in_ready_q;
   assign emit   = out_valid_q && out_ready;

   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      // flush wins over any same-cycle accept or emit
      if (flush) begin
         state_d = StEmpty;
      end else begin
         unique case (state_q)
            StEmpty: begin
               if (accept) begin
                  main_d  = dec;
                  state_d = StOne;
               end
            end
            StOne: begin
               if (accept && emit) begin
                  main_d = dec;
               end else if (accept) begin
                  skid_d  = dec;
                  state_d = StTwo;
               end else if (emit) begin
                  state_d = StEmpty;
               end
            end
            StTwo: begin
               if (emit) begin
                  main_d  = skid_q;
                  state_d = StOne;
               end
            end
            default: state_d = StEmpty;
         endcase
      end
      in_ready_d  = (state_d != StTwo);
      out_valid_d = (state_d != StEmpty);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= StEmpty;
         main_q      <= DecReset;
         skid_q      <= DecReset;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         main_q      <= main_d;
         skid_q      <= skid_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign in_ready    = in_ready_q;
   assign out_valid   = out_valid_q;
   assign out_pc      = main_q.pc;
   assign out_format  = main_q.format;
   assign out_rd      = main_q.rd;
   assign out_rs1     = main_q.rs1;
   assign out_rs2     = main_q.rs2;
   assign out_funct3  = main_q.funct3;
   assign out_funct7  = main_q.funct7;
   assign out_imm     = main_q.imm;
   assign out_illegal = (main_q.format == INVALID_TYPE);

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: field decode, backpressure ordering, flush and reset.

module tb_decode_stage;
   import types::*;

   logic               clk = 1'b0;
   logic               rst_n;
   logic               flush;
   logic               in_valid;
   logic               in_ready;
   logic [31:0]        in_inst;
   logic [31:0]        in_pc;
   logic               out_valid;
   logic               out_ready;
   logic [31:0]        out_pc;
   inst_format_e       out_format;
   logic [4:0]         out_rd;
   logic [4:0]         out_rs1;
   logic [4:0]         out_rs2;
   alu_funct3_e        out_funct3;
   alu_funct7_e        out_funct7;
   logic [31:0]        out_imm;
   logic               out_illegal;

   int total = 0;
   int bad   = 0;

   decode_stage #(.XLEN(32)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .flush       (flush),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_inst     (in_inst),
      .in_pc       (in_pc),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_pc      (out_pc),
      .out_format  (out_format),
      .out_rd      (out_rd),
      .out_rs1     (out_rs1),
      .out_rs2     (out_rs2),
      .out_funct3  (out_funct3),
      .out_funct7  (out_funct7),
      .out_imm     (out_imm),
      .out_illegal (out_illegal)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [31:0] inst, input logic [31:0] pc);
      in_valid = v;
      in_inst  = inst;
      in_pc    = pc;
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_valid"},   32'(out_valid),   32'd0);
      chk({tag, "_ready"},   32'(in_ready),    32'd1);
      chk({tag, "_pc"},      out_pc,           32'h0);
      chk({tag, "_format"},  32'(out_format),  32'(INVALID_TYPE));
      chk({tag, "_rd"},      32'(out_rd),      32'd0);
      chk({tag, "_rs1"},     32'(out_rs1),     32'd0);
      chk({tag, "_rs2"},     32'(out_rs2),     32'd0);
      chk({tag, "_funct3"},  32'(out_funct3),  32'(ADD));
      chk({tag, "_funct7"},  32'(out_funct7),  32'(POS));
      chk({tag, "_imm"},     out_imm,          32'h0);
      chk({tag, "_illegal"}, 32'(out_illegal), 32'd1);
   endtask

   initial begin
      rst_n     = 1'b0;
      flush     = 1'b0;
      out_ready = 1'b0;
      drive(1'b0, 32'h0, 32'h0);
      tick();
      chk_reset_outputs("rst");

      // Streaming decode with out_ready high
      rst_n     = 1'b1;
      out_ready = 1'b1;
      drive(1'b1, 32'h00500093, 32'h100);           // addi x1,x0,5
      tick();
      chk("addi_valid",  32'(out_valid),  32'd1);
      chk("addi_format", 32'(out_format), 32'(I_TYPE));
      chk("addi_rd",     32'(out_rd),     32'd1);
      chk("addi_rs1",    32'(out_rs1),    32'd0);
      chk("addi_funct3", 32'(out_funct3), 32'(ADD));
      chk("addi_imm",    out_imm,         32'h5);
      chk("addi_pc",     out_pc,          32'h100);

      drive(1'b1, 32'h402081B3, 32'h104);           // sub x3,x1,x2
      tick();
      chk("sub_format",  32'(out_format),  32'(R_TYPE));
      chk("sub_funct7",  32'(out_funct7),  32'(NEG));
      chk("sub_rs1",     32'(out_rs1),     32'd1);
      chk("sub_rs2",     32'(out_rs2),     32'd2);
      chk("sub_rd",      32'(out_rd),      32'd3);
      chk("sub_imm",     out_imm,          32'h0);
      chk("sub_illegal", 32'(out_illegal), 32'd0);
      chk("sub_pc",      out_pc,           32'h104);

      drive(1'b1, 32'hFE000EE3, 32'h108);           // beq x0,x0,-4
      tick();
      chk("beq_format", 32'(out_format), 32'(B_TYPE));
      chk("beq_imm",    out_imm,         32'hFFFFFFFC);

      drive(1'b1, 32'h0020A423, 32'h10C);           // sw x2,8(x1)
      tick();
      chk("sw_format", 32'(out_format), 32'(S_TYPE));
      chk("sw_imm",    out_imm,         32'h8);

      drive(1'b1, 32'h123450B7, 32'h110);           // lui x1,0x12345
      tick();
      chk("lui_format", 32'(out_format), 32'(U_TYPE));
      chk("lui_imm",    out_imm,         32'h12345000);

      drive(1'b1, 32'hFFDFF06F, 32'h114);           // jal x0,-4
      tick();
      chk("jal_format", 32'(out_format), 32'(J_TYPE));
      chk("jal_imm",    out_imm,         32'hFFFFFFFC);

      drive(1'b1, 32'h00000000, 32'h118);
      tick();
      chk("zero_format",  32'(out_format),  32'(INVALID_TYPE));
      chk("zero_illegal", 32'(out_illegal), 32'd1);
      chk("zero_imm",     out_imm,          32'h0);

      drive(1'b1, 32'h00500091, 32'h11C);           // low bits 01 -> not RV32I
      tick();
      chk("lowbits_illegal", 32'(out_illegal), 32'd1);
      chk("lowbits_imm",     out_imm,          32'h0);

      drive(1'b0, 32'h0, 32'h0);
      tick();
      chk("drain_valid", 32'(out_valid), 32'd0);

      // Backpressure: A, B, C offered with out_ready low for 3 cycles
      out_ready = 1'b0;
      drive(1'b1, 32'h00A00293, 32'h200);           // A
      tick();
      chk("bp_a_valid", 32'(out_valid), 32'd1);
      chk("bp_a_ready", 32'(in_ready),  32'd1);
      chk("bp_a_pc",    out_pc,         32'h200);
      drive(1'b1, 32'h00B00313, 32'h204);           // B
      tick();
      chk("bp_b_ready", 32'(in_ready), 32'd0);
      chk("bp_b_pc",    out_pc,        32'h200);
      drive(1'b1, 32'h00C00393, 32'h208);           // C held
      tick();
      chk("bp_c_ready", 32'(in_ready), 32'd0);
      chk("bp_c_pc",    out_pc,        32'h200);
      chk("bp_c_imm",   out_imm,       32'hA);
      out_ready = 1'b1;
      tick();
      chk("bp_out_b_pc",  out_pc,          32'h204);
      chk("bp_out_b_imm", out_imm,         32'hB);
      chk("bp_out_b_rdy", 32'(in_ready),   32'd1);
      tick();
      chk("bp_out_c_pc",  out_pc,          32'h208);
      chk("bp_out_c_imm", out_imm,         32'hC);
      chk("bp_out_c_vld", 32'(out_valid),  32'd1);
      drive(1'b0, 32'h0, 32'h0);
      tick();
      chk("bp_end_valid", 32'(out_valid), 32'd0);

      // Flush while two entries are held, with a word offered the same cycle
      out_ready = 1'b0;
      drive(1'b1, 32'h00D00413, 32'h300);
      tick();
      drive(1'b1, 32'h00E00493, 32'h304);
      tick();
      chk("fl_two_ready", 32'(in_ready), 32'd0);
      flush = 1'b1;
      drive(1'b1, 32'h00F00513, 32'h308);
      tick();
      chk("fl_valid", 32'(out_valid), 32'd0);
      chk("fl_ready", 32'(in_ready),  32'd1);
      flush     = 1'b0;
      out_ready = 1'b1;
      drive(1'b0, 32'h0, 32'h0);
      tick();
      chk("fl_dropped_valid", 32'(out_valid), 32'd0);

      // Reset asserted while two entries are held
      out_ready = 1'b0;
      drive(1'b1, 32'h01000593, 32'h400);
      tick();
      drive(1'b1, 32'h01100613, 32'h404);
      tick();
      chk("rs_two_ready", 32'(in_ready), 32'd0);
      rst_n = 1'b0;
      drive(1'b0, 32'h0, 32'h0);
      tick();
      chk_reset_outputs("midrst");
      rst_n     = 1'b1;
      out_ready = 1'b1;
      drive(1'b1, 32'h00500093, 32'h500);
      tick();
      chk("post_rst_valid", 32'(out_valid), 32'd1);
      chk("post_rst_pc",    out_pc,         32'h500);
      chk("post_rst_imm",   out_imm,        32'h5);
      drive(1'b0, 32'h0, 32'h0);
      tick();
      chk("post_rst_drain", 32'(out_valid), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
